// File: rtl/hart_arb_pkg.sv
// rtl/hart_arb_pkg.sv - shared line width default and FSM state encodings for the hart arbiter
package hart_arb_pkg;

    localparam int HMEM_LINE   = 128;
    localparam int DEF_N_HARTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hart_arb_rr_arb.sv
// rtl/hart_arb_rr_arb.sv - combinational round-robin picker: first request at or after ptr, wrapping
module rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/hart_arb.sv
// rtl/hart_arb.sv - round-robin memory arbiter for N harts with atomic bus lock and write invalidates
module hart_arb
    import hart_arb_pkg::*;
#(
    parameter int N_HARTS = DEF_N_HARTS,
    parameter int LINE_W  = HMEM_LINE,
    parameter int ADDR_W  = 64
) (
    input  logic                        h_clk,
    input  logic                        h_rst,
    input  logic [N_HARTS*ADDR_W-1:0]   c_addr,
    input  logic [N_HARTS-1:0]          c_rd,
    input  logic [N_HARTS-1:0]          c_wr,
    input  logic [N_HARTS*LINE_W-1:0]   c_data_wr,
    output logic [LINE_W-1:0]           c_data_rd,
    output logic [N_HARTS-1:0]          c_dv,
    output logic [N_HARTS-1:0]          c_inv,
    output logic [ADDR_W-1:0]           c_inv_addr,
    input  logic [N_HARTS-1:0]          c_amo_req,
    output logic [N_HARTS-1:0]          c_amo_ack,
    output logic [ADDR_W-1:0]           m_addr,
    output logic                        m_rd,
    output logic                        m_wr,
    output logic [LINE_W-1:0]           m_data_out,
    input  logic [LINE_W-1:0]           m_data_in,
    input  logic                        m_dv
);

    localparam int IDX_W = $clog2(N_HARTS);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   g_idx;
    logic [N_HARTS-1:0] g_oh;
    logic               lock_held;
    logic [IDX_W-1:0]   lock_owner;

    logic [N_HARTS-1:0] req_any;
    logic [N_HARTS-1:0] eligible;
    logic [N_HARTS-1:0] d_gnt;
    logic [IDX_W-1:0]   d_idx;
    logic               d_any;
    logic [N_HARTS-1:0] a_gnt;
    logic [IDX_W-1:0]   a_idx;
    logic               a_any;

    // While the bus is locked only the owner may start a data transfer.
    assign req_any  = c_rd | c_wr;
    assign eligible = lock_held ? (req_any & (N_HARTS'(1) << lock_owner)) : req_any;

    rr_arb #(.N(N_HARTS), .IDX_W(IDX_W)) u_data_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (d_gnt),
        .idx (d_idx),
        .any (d_any)
    );

    rr_arb #(.N(N_HARTS), .IDX_W(IDX_W)) u_amo_arb (
        .req (c_amo_req),
        .ptr (rr_ptr),
        .gnt (a_gnt),
        .idx (a_idx),
        .any (a_any)
    );

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            g_idx      <= '0;
            g_oh       <= '0;
            lock_held  <= 1'b0;
            lock_owner <= '0;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_data_out <= '0;
            c_dv       <= '0;
            c_inv      <= '0;
            c_inv_addr <= '0;
            c_data_rd  <= '0;
            c_amo_ack  <= '0;
        end else begin
            c_dv  <= '0;
            c_inv <= '0;

            // Release is independent of the FSM so an in-flight transfer is not disturbed.
            if (lock_held && !c_amo_req[lock_owner]) begin
                lock_held <= 1'b0;
                c_amo_ack <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (!lock_held && a_any) begin
                        lock_held  <= 1'b1;
                        lock_owner <= a_idx;
                        c_amo_ack  <= a_gnt;
                    end else if (d_any) begin
                        g_idx      <= d_idx;
                        g_oh       <= d_gnt;
                        m_addr     <= c_addr[d_idx*ADDR_W +: ADDR_W];
                        m_data_out <= c_data_wr[d_idx*LINE_W +: LINE_W];
                        m_wr       <= c_wr[d_idx];
                        m_rd       <= !c_wr[d_idx];
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_dv) begin
                        c_data_rd <= m_data_in;
                        m_rd      <= 1'b0;
                        m_wr      <= 1'b0;
                        c_dv      <= g_oh;
                        if (m_wr) begin
                            c_inv      <= ~g_oh;
                            c_inv_addr <= m_addr;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (g_idx == IDX_W'(N_HARTS - 1)) ? '0 : g_idx + 1'b1;
                    state  <= ST_GAP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hart_arb.sv
// tb/tb_hart_arb.sv - directed table-driven bench for hart_arb with lock, fairness and reset sequences
module tb_hart_arb;

    localparam int N  = 4;
    localparam int LW = 128;
    localparam int AW = 64;

    logic              h_clk = 1'b0;
    logic              h_rst;
    logic [N*AW-1:0]   c_addr;
    logic [N-1:0]      c_rd, c_wr;
    logic [N*LW-1:0]   c_data_wr;
    logic [LW-1:0]     c_data_rd;
    logic [N-1:0]      c_dv, c_inv;
    logic [AW-1:0]     c_inv_addr;
    logic [N-1:0]      c_amo_req, c_amo_ack;
    logic [AW-1:0]     m_addr;
    logic              m_rd, m_wr;
    logic [LW-1:0]     m_data_out, m_data_in;
    logic              m_dv;

    int errors = 0;
    int checks = 0;

    hart_arb #(.N_HARTS(N), .LINE_W(LW), .ADDR_W(AW)) dut (
        .h_clk      (h_clk),
        .h_rst      (h_rst),
        .c_addr     (c_addr),
        .c_rd       (c_rd),
        .c_wr       (c_wr),
        .c_data_wr  (c_data_wr),
        .c_data_rd  (c_data_rd),
        .c_dv       (c_dv),
        .c_inv      (c_inv),
        .c_inv_addr (c_inv_addr),
        .c_amo_req  (c_amo_req),
        .c_amo_ack  (c_amo_ack),
        .m_addr     (m_addr),
        .m_rd       (m_rd),
        .m_wr       (m_wr),
        .m_data_out (m_data_out),
        .m_data_in  (m_data_in),
        .m_dv       (m_dv)
    );

    always #5 h_clk = ~h_clk;

    typedef struct {
        int           hart;
        bit           rd;
        bit           wr;
        logic [63:0]  addr;
        logic [127:0] wdata;
        logic [127:0] mdata;
        int           dly;
        bit           exp_wr;
        logic [3:0]   exp_dv;
        logic [3:0]   exp_inv;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge h_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        h_rst = 1'b1;
        step();
        step();
        h_rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        c_addr[v.hart*AW +: AW]    = v.addr;
        c_data_wr[v.hart*LW +: LW] = v.wdata;
        c_rd[v.hart]               = v.rd;
        c_wr[v.hart]               = v.wr;
        step();
        chk("vec m_rd", m_rd, !v.exp_wr);
        chk("vec m_wr", m_wr, v.exp_wr);
        chk("vec m_addr", m_addr, v.addr);
        if (v.exp_wr) chk("vec m_data_out", m_data_out, v.wdata);
        for (int i = 1; i < v.dly; i++) step();
        chk("vec m_rd held", m_rd, !v.exp_wr);
        chk("vec c_dv busy", c_dv, 4'b0000);
        m_dv      = 1'b1;
        m_data_in = v.mdata;
        step();
        m_dv = 1'b0;
        chk("vec c_dv", c_dv, v.exp_dv);
        chk("vec c_inv", c_inv, v.exp_inv);
        chk("vec m_rd drop", m_rd | m_wr, 1'b0);
        if (v.exp_wr) chk("vec c_inv_addr", c_inv_addr, v.addr);
        else          chk("vec c_data_rd", c_data_rd, v.mdata);
        c_rd[v.hart] = 1'b0;
        c_wr[v.hart] = 1'b0;
        step();
        chk("vec c_dv gap", c_dv, 4'b0000);
        chk("vec c_inv gap", c_inv, 4'b0000);
        step();
    endtask

    initial begin
        logic [3:0] fair_oh[5];
        int         fair_h[5];

        h_rst = 1'b1; c_addr = '0; c_rd = '0; c_wr = '0; c_data_wr = '0;
        c_amo_req = '0; m_data_in = '0; m_dv = 1'b0;

        vecs[0] = '{2, 1'b1, 1'b0, 64'h1000, 128'h0, {16{8'hA5}}, 3, 1'b0, 4'b0100, 4'b0000};
        vecs[1] = '{1, 1'b0, 1'b1, 64'h2040, 128'h1234_5678_9ABC_DEF0, 128'h0, 2, 1'b1, 4'b0010, 4'b1101};
        vecs[2] = '{0, 1'b1, 1'b1, 64'h3000, 128'hCAFE, 128'h0, 1, 1'b1, 4'b0001, 4'b1110};
        vecs[3] = '{3, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 128'h0, {8{16'h5A3C}}, 1, 1'b0, 4'b1000, 4'b0000};
        vecs[4] = '{0, 1'b0, 1'b1, 64'h40, {4{32'hDEAD_BEEF}}, 128'h0, 5, 1'b1, 4'b0001, 4'b1110};

        do_reset();
        chk("rst m_rd", m_rd, 1'b0);
        chk("rst m_wr", m_wr, 1'b0);
        chk("rst c_dv", c_dv, 4'b0000);
        chk("rst c_inv", c_inv, 4'b0000);
        chk("rst c_amo_ack", c_amo_ack, 4'b0000);
        chk("rst m_addr", m_addr, 64'h0);
        chk("rst c_data_rd", c_data_rd, 128'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fairness: every hart reads continuously, grants rotate 0,1,2,3,0.
        do_reset();
        fair_h  = '{0, 1, 2, 3, 0};
        fair_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) c_addr[i*AW +: AW] = 64'(32'h100 * (i + 1));
        c_rd = 4'hF;
        step();
        for (int n = 0; n < 5; n++) begin
            chk("fair m_rd", m_rd, 1'b1);
            chk("fair m_addr", m_addr, 64'(32'h100 * (fair_h[n] + 1)));
            step();
            m_dv = 1'b1; m_data_in = 128'(n);
            step();
            m_dv = 1'b0;
            chk("fair c_dv", c_dv, fair_oh[n]);
            step();
            chk("fair gap m_rd", m_rd, 1'b0);
            step();
            chk("fair idle m_rd", m_rd, 1'b0);
            step();
        end
        c_rd = '0;
        m_dv = 1'b1;
        step();
        m_dv = 1'b0;
        step(); step(); step();

        // Lock: amo wins over a simultaneous data request and masks non-owners.
        do_reset();
        c_addr[0*AW +: AW] = 64'hA000;
        c_addr[3*AW +: AW] = 64'hB000;
        c_amo_req[3] = 1'b1;
        c_rd[0]      = 1'b1;
        step();
        chk("lock ack", c_amo_ack, 4'b1000);
        chk("lock defer m_rd", m_rd, 1'b0);
        step(); step(); step();
        chk("lock block m_rd", m_rd, 1'b0);
        c_rd[3] = 1'b1;
        step();
        chk("lock owner m_rd", m_rd, 1'b1);
        chk("lock owner addr", m_addr, 64'hB000);
        m_dv = 1'b1; m_data_in = 128'h77;
        step();
        m_dv = 1'b0;
        chk("lock owner c_dv", c_dv, 4'b1000);
        chk("lock ack held", c_amo_ack, 4'b1000);
        c_rd[3] = 1'b0;
        step(); step(); step();
        chk("lock still block", m_rd, 1'b0);
        c_amo_req[3] = 1'b0;
        step();
        chk("lock release ack", c_amo_ack, 4'b0000);
        chk("lock release m_rd", m_rd, 1'b0);
        step();
        chk("lock after m_rd", m_rd, 1'b1);
        chk("lock after addr", m_addr, 64'hA000);
        m_dv = 1'b1; m_data_in = 128'h88;
        step();
        m_dv = 1'b0;
        chk("lock after c_dv", c_dv, 4'b0001);
        c_rd[0] = 1'b0;
        step(); step();

        // Reset in BUSY: transfer abandoned, late m_dv ignored, rr_ptr back to 0.
        c_addr[1*AW +: AW] = 64'hC000;
        c_rd[1] = 1'b1;
        step();
        chk("rbusy m_rd", m_rd, 1'b1);
        h_rst = 1'b1;
        step();
        h_rst   = 1'b0;
        c_rd[1] = 1'b0;
        chk("rbusy m_rd rst", m_rd, 1'b0);
        chk("rbusy m_addr rst", m_addr, 64'h0);
        m_dv = 1'b1; m_data_in = 128'h99;
        step();
        m_dv = 1'b0;
        chk("rbusy c_dv", c_dv, 4'b0000);
        chk("rbusy c_data_rd", c_data_rd, 128'h0);
        step();
        chk("rbusy c_dv later", c_dv, 4'b0000);
        chk("rbusy idle m_rd", m_rd, 1'b0);
        c_addr[0*AW +: AW] = 64'hD000;
        c_addr[3*AW +: AW] = 64'hE000;
        c_rd[0] = 1'b1;
        c_rd[3] = 1'b1;
        step();
        chk("rbusy ptr0 addr", m_addr, 64'hD000);
        m_dv = 1'b1; m_data_in = 128'h5;
        step();
        m_dv = 1'b0;
        chk("rbusy ptr0 c_dv", c_dv, 4'b0001);
        c_rd = '0;
        step(); step();

        // m_dv while IDLE must not complete anything or disturb c_data_rd.
        m_dv = 1'b1; m_data_in = 128'hDEAD;
        step();
        m_dv = 1'b0;
        chk("idle m_dv c_dv", c_dv, 4'b0000);
        chk("idle m_dv data", c_data_rd, 128'h5);
        chk("idle m_dv m_rd", m_rd, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
